sync_mem: RTL and testbench

SYNC_MEM -- requirements
Module: sync_mem

---
 rtl/sync_mem.sv | 72 +++++++
 tb/tb_sync_mem.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sync_mem.sv
// sync_mem: word-addressed RAM cleared by hardware after reset, fixed-latency in-order responses
module sync_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int LATENCY = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int NB = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH * NB);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [IW-1:0] clr_idx, clr_nx, idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, err;
  logic [LATENCY-1:0] pv, pe;
  logic [DATA_W-1:0] pd [LATENCY];
  assign idx = req_addr[OFF+IW-1:OFF];
  assign acc = req_valid && req_ready;
  assign err = (|req_addr[OFF-1:0]) || ({1'b0, req_addr} >= LIM);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nx;
      clr_idx <= clr_nx;
    end
  always_comb begin
    req_ready = state == READY;
    state_nx = (state == CLEAR && clr_idx == IW'(DEPTH - 1)) ? READY : state;
    clr_nx = state == CLEAR ? clr_idx + 1'b1 : clr_idx;
  end
  always_ff @(posedge clk)
    if (state == CLEAR)
      mem[clr_idx] <= '0;
    else if (acc && req_we && !err)
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  // read data is captured at the accept edge; pd stays zero for idle slots, writes and errors
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= acc;
      pe[0] <= acc && err;
      pd[0] <= (acc && !req_we && !err) ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  assign rsp_valid = pv[LATENCY-1];
  assign rsp_err = pe[LATENCY-1];
  assign rsp_rdata = pd[LATENCY-1];
endmodule

// File: tb/tb_sync_mem.sv
// tb_sync_mem: three sync_mem builds (LATENCY 2, 1, 4) on shared stimulus, scoreboard per build
module tb_sync_mem;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] model [256];
  typedef struct {int c; logic e; logic [31:0] d;} ent_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : m
    localparam int L = g == 0 ? 2 : g == 1 ? 1 : 4;
    logic rdy, rv, re;
    logic [31:0] rd;
    ent_t q[$];
    ent_t e;
    sync_mem #(.DATA_W(32), .DEPTH(256), .LATENCY(L), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv), .rsp_rdata(rd), .rsp_err(re));
    always @(negedge clk) if (rst_n) begin
      checks++;
      if (rv) begin
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp L=%0d cyc=%0d rdata=%h err=%b", L, cyc, rd, re);
        end else begin
          e = q.pop_front();
          if (cyc !== e.c || re !== e.e || rd !== e.d) begin
            failures++;
            $display("FAIL rsp L=%0d cyc=%0d want %0d err=%b want %b rdata=%h want %h",
                     L, cyc, e.c, re, e.e, rd, e.d);
          end
        end
      end else if (re !== 1'b0 || rd !== 32'h0) begin
        failures++;
        $display("FAIL idle_outputs L=%0d cyc=%0d rdata=%h err=%b want 0", L, cyc, rd, re);
      end
    end
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic er;
    logic [7:0] ix;
    logic [31:0] x;
    er = a[1:0] != 2'b0 || a >= 32'h400;
    ix = a[9:2];
    x = 0;
    if (!er && we)
      for (int i = 0; i < 4; i++) if (be[i]) model[ix][8*i +: 8] = d[8*i +: 8];
    if (!er && !we) x = model[ix];
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    m[0].q.push_back(ent_t'{cyc + 2, er, x});
    m[1].q.push_back(ent_t'{cyc + 1, er, x});
    m[2].q.push_back(ent_t'{cyc + 4, er, x});
  endtask

  task automatic idle;
    req_valid = 0; req_we = 1'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
    step();
  endtask

  task automatic drain;
    idle();
    repeat (6) step();
    checks++;
    if (m[0].q.size() != 0 || m[1].q.size() != 0 || m[2].q.size() != 0) begin
      failures++;
      $display("FAIL missing_rsp pending=%0d/%0d/%0d want 0/0/0",
               m[0].q.size(), m[1].q.size(), m[2].q.size());
    end
  endtask

  task automatic apply_reset;
    rst_n = 0; req_valid = 0;
    m[0].q.delete(); m[1].q.delete(); m[2].q.delete();
    for (int i = 0; i < 256; i++) model[i] = 0;
    repeat (2) step();
    checks++;
    if ({m[0].rdy, m[0].rv, m[0].re, m[1].rdy, m[1].rv, m[1].re, m[2].rdy, m[2].rv, m[2].re} !== 9'b0 ||
        (m[0].rd | m[1].rd | m[2].rd) !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs rdy=%b%b%b rv=%b%b%b rdata=%h want all 0",
               m[0].rdy, m[1].rdy, m[2].rdy, m[0].rv, m[1].rv, m[2].rv, m[0].rd);
    end
    rst_n = 1;
  endtask

  task automatic wait_clear;
    int n = 0;
    while (!m[0].rdy && n < 1000) begin
      n++;
      step();
    end
    checks++;
    if (n !== 256 || m[1].rdy !== 1'b1 || m[2].rdy !== 1'b1) begin
      failures++;
      $display("FAIL clear_cycles got %0d rdy=%b%b%b want 256 rdy=111", n, m[0].rdy, m[1].rdy, m[2].rdy);
    end
  endtask

  task automatic test_reset;
    apply_reset();
    repeat (100) step();
    checks++;
    if (m[0].rdy !== 1'b0) begin
      failures++;
      $display("FAIL ready_mid_clear got %b want 0", m[0].rdy);
    end
    apply_reset();
    wait_clear();
    issue(0, 32'h3FC, 0, 4'hF); step();
    drain();
  endtask

  task automatic test_write_read;
    issue(1, 32'h64, 32'h11223344, 4'hF); step();
    issue(0, 32'h64, 0, 4'h0); step();
    drain();
  endtask

  task automatic test_byte_enable;
    issue(1, 32'h68, 32'hAABBCCDD, 4'h5); step();
    issue(0, 32'h68, 0, 4'hF); step();
    issue(1, 32'h64, 32'hDEADBEEF, 4'h0); step();
    issue(0, 32'h64, 0, 4'h0); step();
    drain();
    checks++;
    if (model[26] !== 32'h00BB00DD) begin
      failures++;
      $display("FAIL be_merge got %h want 00bb00dd", model[26]);
    end
  endtask

  task automatic test_errors;
    issue(0, 32'h66, 0, 4'hF); step();
    issue(1, 32'h400, 32'hCAFEF00D, 4'hF); step();
    issue(0, 32'h400, 0, 4'hF); step();
    issue(1, 32'h65, 32'h55555555, 4'hF); step();
    issue(1, 32'hFFFFFFFC, 32'h77777777, 4'hF); step();
    issue(0, 32'h64, 0, 4'hF); step();
    issue(0, 32'h0, 0, 4'hF); step();
    issue(0, 32'h3FC, 0, 4'hF); step();
    drain();
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1100)) : 32'h60 + 32'(4 * $urandom_range(0, 7));
      issue(1'($urandom), a, $urandom, 4'($urandom));
      step();
    end
    drain();
  endtask

  task automatic test_reset_inflight;
    issue(1, 32'h70, 32'h0BADCAFE, 4'hF); step();
    idle();
    repeat (6) step();
    issue(0, 32'h70, 0, 4'hF); step();
    issue(0, 32'h64, 0, 4'hF);
    @(posedge clk);
    #1;
    apply_reset();
    wait_clear();
    issue(0, 32'h70, 0, 4'hF); step();
    issue(0, 32'h64, 0, 4'hF); step();
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
